// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL lock sequencer: FSM state encoding
// and counter sizing.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2,
    HOLD      = 2'd3
  } state_e;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous bit, with synchronous
// active-low reset. Reusable for any asynchronous level input.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  assign sync_d = {sync_q[STAGES-2:0], d};

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values; blocking here would collapse the chain into one stage.
  always_ff @(posedge clk) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Releases the 96 MHz domain's synchronous reset once the PLL lock flag has
// been stable long enough; re-asserts it on lock loss and counts losses.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int STABLE_CYCLES = 9600,
  parameter int HOLD_CYCLES   = 16,
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pll_locked,
  input  logic             clear_stats,
  output logic             sys_rst_n,
  output logic             ready,
  output logic             lock_lost,
  output logic [CNT_W-1:0] loss_count,
  output logic [1:0]       state
);

  localparam int SW = cnt_width(STABLE_CYCLES);
  localparam int HW = cnt_width(HOLD_CYCLES);
  localparam logic [SW-1:0]    STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0]    HOLD_LAST   = HW'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  logic locked_s;

  bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pll_locked),
    .q       (locked_s)
  );

  state_e           state_q, state_d;
  logic [SW-1:0]    stable_cnt_q, stable_cnt_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             ready_q, ready_d;
  logic             lock_lost_q, lock_lost_d;
  logic [CNT_W-1:0] loss_count_q, loss_count_d;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_d      = state_q;
    stable_cnt_d = '0;
    hold_cnt_d   = '0;
    lock_lost_d  = 1'b0;

    case (state_q)
      WAIT_LOCK: if (locked_s) state_d = STABILIZE;
      STABILIZE: begin
        if (!locked_s)                     state_d = WAIT_LOCK;
        else if (stable_cnt_q == STABLE_LAST) state_d = RUN;
        else                               stable_cnt_d = stable_cnt_q + SW'(1);
      end
      RUN: begin
        if (!locked_s) begin
          state_d     = HOLD;
          lock_lost_d = 1'b1;
        end
      end
      HOLD: begin
        // Leaves after a fixed time whatever the lock flag does meanwhile.
        if (hold_cnt_q == HOLD_LAST) state_d = WAIT_LOCK;
        else                         hold_cnt_d = hold_cnt_q + HW'(1);
      end
      default: state_d = WAIT_LOCK;
    endcase

    sys_rst_n_d = (state_d == RUN);
    ready_d     = sys_rst_n_d & sys_rst_n_q;

    // A clear coinciding with a loss still records that loss.
    loss_count_d = loss_count_q;
    if (clear_stats)
      loss_count_d = lock_lost_d ? CNT_W'(1) : '0;
    else if (lock_lost_d && (loss_count_q != CNT_MAX))
      loss_count_d = loss_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= WAIT_LOCK;
      stable_cnt_q <= '0;
      hold_cnt_q   <= '0;
      sys_rst_n_q  <= 1'b0;
      ready_q      <= 1'b0;
      lock_lost_q  <= 1'b0;
      loss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      stable_cnt_q <= stable_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      sys_rst_n_q  <= sys_rst_n_d;
      ready_q      <= ready_d;
      lock_lost_q  <= lock_lost_d;
      loss_count_q <= loss_count_d;
    end
  end

  assign sys_rst_n  = sys_rst_n_q;
  assign ready      = ready_q;
  assign lock_lost  = lock_lost_q;
  assign loss_count = loss_count_q;
  assign state      = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with STABLE=8, HOLD=4, SYNC=2, CNT_W=2;
// expected values are hand-derived edge counts from each stimulus change.
module tb_pll_lock_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       clear_stats;
  logic       sys_rst_n;
  logic       ready;
  logic       lock_lost;
  logic [1:0] loss_count;
  logic [1:0] state;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [1:0] S_WAIT = 2'd0, S_STAB = 2'd1, S_RUN = 2'd2, S_HOLD = 2'd3;

  pll_lock_sequencer #(
    .STABLE_CYCLES (8),
    .HOLD_CYCLES   (4),
    .SYNC_STAGES   (2),
    .CNT_W         (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pll_locked  (pll_locked),
    .clear_stats (clear_stats),
    .sys_rst_n   (sys_rst_n),
    .ready       (ready),
    .lock_lost   (lock_lost),
    .loss_count  (loss_count),
    .state       (state)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, landing 2 time units after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Loss from RUN, optional clear on the loss edge, then re-lock back to ready.
  task automatic do_loss(input logic with_clear, input logic [1:0] exp_count);
    pll_locked = 1'b0;
    tick(2);
    clear_stats = with_clear;
    tick(1);
    clear_stats = 1'b0;
    check("loss_pulse", 8'(lock_lost), 8'd1);
    check("loss_rst",   8'(sys_rst_n), 8'd0);
    check("loss_count", 8'(loss_count), 8'(exp_count));
    tick(1);
    check("loss_pulse_end", 8'(lock_lost), 8'd0);
    pll_locked = 1'b1;
    tick(13);
    check("relock_state", 8'(state), 8'(S_RUN));
    check("relock_ready", 8'(ready), 8'd1);
  endtask

  initial begin
    reset_n     = 1'b0;
    pll_locked  = 1'b0;
    clear_stats = 1'b0;

    // Reset state
    tick(3);
    check("rst_sys_rst_n", 8'(sys_rst_n), 8'd0);
    check("rst_ready",     8'(ready), 8'd0);
    check("rst_lock_lost", 8'(lock_lost), 8'd0);
    check("rst_loss",      8'(loss_count), 8'd0);
    check("rst_state",     8'(state), 8'(S_WAIT));
    reset_n = 1'b1;
    tick(2);
    check("idle_state", 8'(state), 8'(S_WAIT));

    // Clean lock: first sampled high at edge E
    pll_locked = 1'b1;
    tick(2);
    check("clean_e1_state", 8'(state), 8'(S_WAIT));
    tick(1);
    check("clean_e2_state", 8'(state), 8'(S_STAB));
    tick(7);
    check("clean_e9_rst", 8'(sys_rst_n), 8'd0);
    tick(1);
    check("clean_e10_rst",   8'(sys_rst_n), 8'd1);
    check("clean_e10_ready", 8'(ready), 8'd0);
    check("clean_e10_state", 8'(state), 8'(S_RUN));
    tick(1);
    check("clean_e11_ready", 8'(ready), 8'd1);
    check("clean_loss",      8'(loss_count), 8'd0);

    // Loss in RUN: drop sampled at edge D
    pll_locked = 1'b0;
    tick(2);
    check("drop_d1_rst",   8'(sys_rst_n), 8'd1);
    check("drop_d1_pulse", 8'(lock_lost), 8'd0);
    tick(1);
    check("drop_d2_state", 8'(state), 8'(S_HOLD));
    check("drop_d2_rst",   8'(sys_rst_n), 8'd0);
    check("drop_d2_ready", 8'(ready), 8'd0);
    check("drop_d2_pulse", 8'(lock_lost), 8'd1);
    check("drop_d2_loss",  8'(loss_count), 8'd1);
    pll_locked = 1'b1;
    tick(1);
    check("drop_d3_pulse", 8'(lock_lost), 8'd0);
    tick(2);
    check("hold_d5_state", 8'(state), 8'(S_HOLD));
    tick(1);
    check("hold_d6_state", 8'(state), 8'(S_WAIT));
    tick(1);
    check("hold_d7_state", 8'(state), 8'(S_STAB));
    tick(7);
    check("relock_d14_rst", 8'(sys_rst_n), 8'd0);
    tick(1);
    check("relock_d15_rst", 8'(sys_rst_n), 8'd1);
    tick(1);
    check("relock_d16_ready", 8'(ready), 8'd1);

    // Glitch during STABILIZE, starting from WAIT_LOCK
    pll_locked = 1'b0;
    tick(3);
    check("g_loss2", 8'(loss_count), 8'd2);
    tick(6);
    check("g_wait", 8'(state), 8'(S_WAIT));
    pll_locked = 1'b1;
    tick(5);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(1);
    check("g6_state", 8'(state), 8'(S_STAB));
    tick(1);
    check("g7_state", 8'(state), 8'(S_WAIT));
    check("g7_pulse", 8'(lock_lost), 8'd0);
    tick(1);
    check("g8_state", 8'(state), 8'(S_STAB));
    tick(2);
    check("g10_rst", 8'(sys_rst_n), 8'd0);
    tick(5);
    check("g15_rst", 8'(sys_rst_n), 8'd0);
    tick(1);
    check("g16_rst", 8'(sys_rst_n), 8'd1);
    tick(1);
    check("g17_ready", 8'(ready), 8'd1);
    check("g17_loss",  8'(loss_count), 8'd2);

    // Saturation and clear
    do_loss(1'b0, 2'd3);
    do_loss(1'b0, 2'd3);
    clear_stats = 1'b1;
    tick(1);
    clear_stats = 1'b0;
    check("clear_alone", 8'(loss_count), 8'd0);
    do_loss(1'b1, 2'd1);

    // Reset mid-RUN, then full lock sequence again
    reset_n = 1'b0;
    tick(1);
    check("mrst_rst",   8'(sys_rst_n), 8'd0);
    check("mrst_ready", 8'(ready), 8'd0);
    check("mrst_pulse", 8'(lock_lost), 8'd0);
    check("mrst_loss",  8'(loss_count), 8'd0);
    check("mrst_state", 8'(state), 8'(S_WAIT));
    reset_n = 1'b1;
    tick(10);
    check("mrst_r10_rst",   8'(sys_rst_n), 8'd0);
    check("mrst_r10_state", 8'(state), 8'(S_STAB));
    tick(1);
    check("mrst_r11_rst", 8'(sys_rst_n), 8'd1);
    tick(1);
    check("mrst_r12_ready", 8'(ready), 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
